sync_gate_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single registered AND stage among `NREQ` requesters. The stage computes `a & b` and captures it on the rising clock edge. Each cycle the block grants at most one requester, drives that requester's operands through the shared AND stage, and returns the registered result tagged with the requester index. The result is delivered over a valid/ready response port with full backpressure. The block sits between independent producer blocks and one downstream consumer of gated results.

---
 rtl/sync_gate_arbiter.sv | 113 +++++++++++
 tb/tb_sync_gate_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sync_gate_arbiter.sv
// Round-robin arbiter sharing one registered AND stage
// among NREQ requesters, with a valid/ready result port.
module sync_gate_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_q,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [IDW-1:0]   id_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_found;
  logic             can_grant;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  assign rsp_valid = (state == FULL);
  assign can_grant = !rsp_valid || rsp_ready;
  assign busy      = rsp_valid || (|req_valid);

  // Search starts at ptr and wraps, so the last winner goes last.
  always_comb begin : sel
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(j);
      end
    end
  end

  assign grant = gnt_found && can_grant && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready = NREQ'(1) << gnt_idx;
    end
  end

  assign a_sel = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_nxt = state;
    q_nxt     = rsp_q;
    id_nxt    = rsp_id;
    ptr_nxt   = ptr;
    if (grant) begin
      q_nxt  = a_sel & b_sel;
      id_nxt = gnt_idx;
      if (gnt_idx == IDW'(NREQ - 1)) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = gnt_idx + 1'b1;
      end
    end
    unique case (state)
      EMPTY: begin
        if (grant) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (!grant && rsp_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      rsp_q  <= '0;
      rsp_id <= '0;
      ptr    <= '0;
    end else begin
      state  <= state_nxt;
      rsp_q  <= q_nxt;
      rsp_id <= id_nxt;
      ptr    <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_sync_gate_arbiter.sv
// Directed bench for sync_gate_arbiter; expected results
// queue up at grant time and a monitor checks deliveries.
module tb_sync_gate_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_q;
  logic [1:0]  rsp_id;
  logic        busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] q;
  } rsp_t;

  rsp_t       sb[$];
  int         vectors;
  int         miscompares;
  logic [7:0] exp_tab [4];

  sync_gate_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_q     (rsp_q),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] v,
                     input logic rdy,
                     input logic [3:0] er,
                     input string nm);
    rsp_t e;
    req_valid = v;
    rsp_ready = rdy;
    @(negedge clk);
    chk(nm, 32'(req_ready), 32'(er));
    for (int i = 0; i < 4; i++) begin
      if (er[i]) begin
        e.id = 2'(i);
        e.q  = exp_tab[i];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_q", 32'(rsp_q), 32'(e.q));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_tab     = '{8'h55, 8'h0F, 8'h30, 8'h81};
    req_a       = {8'hC3, 8'hF0, 8'h0F, 8'h55};
    req_b       = {8'h81, 8'h3C, 8'hFF, 8'hFF};
    rst         = 1'b1;
    req_valid   = 4'hF;
    rsp_ready   = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_q", 32'(rsp_q), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    cyc(4'hF, 1'b1, 4'b0001, "first_grant");
    cyc(4'hF, 1'b1, 4'b0010, "load_1");
    cyc(4'hF, 1'b1, 4'b0100, "load_2");
    cyc(4'hF, 1'b1, 4'b1000, "load_3");
    cyc(4'hF, 1'b1, 4'b0001, "load_0");
    cyc(4'hF, 1'b1, 4'b0010, "load_1b");

    repeat (3) begin
      cyc(4'b1001, 1'b0, 4'b0000, "bp_ready");
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_q", 32'(rsp_q), 32'h0F);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    cyc(4'b1001, 1'b1, 4'b1000, "bp_release");

    cyc(4'b0001, 1'b1, 4'b0001, "wrap");
    cyc(4'b0011, 1'b1, 4'b0010, "ptr_after_wrap");

    rst = 1'b1;
    cyc(4'b1010, 1'b0, 4'b0000, "midrst_ready");
    sb.delete();
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_q", 32'(rsp_q), 32'd0);
    chk("midrst_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;

    cyc(4'b1010, 1'b1, 4'b0010, "post_rst_grant");
    cyc(4'b1000, 1'b1, 4'b1000, "post_rst_next");
    cyc(4'b0100, 1'b1, 4'b0100, "single");
    cyc(4'b0000, 1'b1, 4'b0000, "drain");
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
